// File: rtl/display_pkg.sv
// Shared constants, arbiter state type and frame helpers for the
// multiplexed seven-segment display scheduler.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int SRC_DEF = 0;
    localparam int SRC_OV1 = 1;
    localparam int SRC_OV2 = 2;

    localparam logic [2:0] GRANT_DEF = 3'b001;
    localparam logic [2:0] GRANT_OV1 = 3'b010;
    localparam logic [2:0] GRANT_OV2 = 3'b100;

    typedef enum logic [1:0] {
        ARB_DEFAULT,
        ARB_OV1,
        ARB_OV2
    } arb_state_t;

    function automatic logic [2:0] grant_of(arb_state_t s);
        case (s)
            ARB_OV1: return GRANT_OV1;
            ARB_OV2: return GRANT_OV2;
            default: return GRANT_DEF;
        endcase
    endfunction

    function automatic logic [3:0] digit_of(logic [15:0] f, logic [1:0] idx);
        return f[int'(idx) * 4 +: 4];
    endfunction

    // Digit idx is a leading zero when it and every digit above it are 0;
    // digit 0 always stays visible so a zero value still shows "0".
    function automatic logic leading_zero(logic [15:0] f, logic [1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && f[k * 4 +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 2'd0) && all_zero;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides the system clock to the digit scan rate and tracks the
// anti-ghost blank window that follows every digit step.
module scan_prescaler #(
    parameter int DIV = 50_000,
    parameter int GAP = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic gap_next
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [CW-1:0] count;
    logic [GW-1:0] gap_left;
    logic          waiting_first;

    assign tick = (count == CW'(DIV - 1));

    // gap_next is the blank state for the cycle after the coming edge, so the
    // top level can register it in step with SEL.
    assign gap_next = tick ? (GAP > 0) : (waiting_first || gap_left != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            gap_left      <= '0;
            waiting_first <= 1'b1;
        end else if (tick) begin
            count         <= '0;
            gap_left      <= GW'((GAP > 0) ? GAP - 1 : 0);
            waiting_first <= 1'b0;
        end else begin
            count <= count + 1'b1;
            if (gap_left != '0) begin
                gap_left <= gap_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Digit scan controller and three-source display arbiter; frames are
// latched only at the scan wrap so a frame never mixes two sources.
module display_scheduler
    import display_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int HOLD_TICKS = 500,
    parameter int GAP_CYC    = 2500
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        lzb_en,
    input  logic [15:0] src0_data,
    input  logic        src1_req,
    input  logic [15:0] src1_data,
    input  logic        src2_req,
    input  logic [15:0] src2_data,
    output logic [1:0]  SEL,
    output logic [3:0]  Y,
    output logic        blank,
    output logic [2:0]  grant,
    output logic        frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int HW  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    logic        tick;
    logic        gap_next;
    logic        boundary;
    arb_state_t  state, state_next;
    logic [HW-1:0] hold, hold_next;
    logic [15:0] frame, frame_next;
    logic [1:0]  sel_next;
    logic [15:0] src_data [3];

    scan_prescaler #(
        .DIV (DIV),
        .GAP (GAP_CYC)
    ) u_prescaler (
        .clk      (clk_50M),
        .rst      (rst),
        .tick     (tick),
        .gap_next (gap_next)
    );

    assign src_data[SRC_DEF] = src0_data;
    assign src_data[SRC_OV1] = src1_data;
    assign src_data[SRC_OV2] = src2_data;

    assign boundary = tick && (SEL == 2'(NUM_DIGITS - 1));
    assign sel_next = tick ? SEL + 2'd1 : SEL;

    always_comb begin
        state_next = state;
        if (boundary) begin
            case (state)
                ARB_DEFAULT: begin
                    if (src2_req)      state_next = ARB_OV2;
                    else if (src1_req) state_next = ARB_OV1;
                end
                ARB_OV1: begin
                    if (src2_req)                         state_next = ARB_OV2;
                    else if (!src1_req && hold == '0)     state_next = ARB_DEFAULT;
                end
                ARB_OV2: begin
                    if (!src2_req && hold == '0) begin
                        state_next = src1_req ? ARB_OV1 : ARB_DEFAULT;
                    end
                end
                default: state_next = ARB_DEFAULT;
            endcase
        end
    end

    // Any change into an overlay (including OV1->OV2 preemption and the
    // OV2->OV1 fall-back) restarts the minimum display time.
    always_comb begin
        hold_next = hold;
        if (state_next == ARB_DEFAULT) begin
            hold_next = '0;
        end else if (state_next != state) begin
            hold_next = HW'(HOLD_TICKS);
        end else if (tick && hold != '0) begin
            hold_next = hold - 1'b1;
        end
    end

    always_comb begin
        frame_next = frame;
        if (boundary) begin
            case (state_next)
                ARB_OV1: frame_next = src_data[SRC_OV1];
                ARB_OV2: frame_next = src_data[SRC_OV2];
                default: frame_next = src_data[SRC_DEF];
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state      <= ARB_DEFAULT;
            hold       <= '0;
            frame      <= '0;
            SEL        <= '0;
            Y          <= '0;
            blank      <= 1'b1;
            grant      <= GRANT_DEF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            hold       <= hold_next;
            frame      <= frame_next;
            SEL        <= sel_next;
            Y          <= digit_of(frame_next, sel_next);
            blank      <= gap_next | (lzb_en & leading_zero(frame_next, sel_next));
            grant      <= grant_of(state_next);
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Scenario bench for display_scheduler: each digit step is compared against
// an expectation queued when the stimulus for it was applied.
module tb_display_scheduler;

    logic        clk_50M;
    logic        rst;
    logic        lzb_en;
    logic [15:0] src0_data;
    logic        src1_req;
    logic [15:0] src1_data;
    logic        src2_req;
    logic [15:0] src2_data;
    logic [1:0]  SEL;
    logic [3:0]  Y;
    logic        blank;
    logic [2:0]  grant;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] y;
        logic [2:0] grant;
        logic       ft;
        logic       blank;
        int         act;
    } step_t;

    step_t sb[$];

    display_scheduler #(
        .CLK_HZ     (40),
        .SCAN_HZ    (10),
        .HOLD_TICKS (6),
        .GAP_CYC    (1)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .lzb_en     (lzb_en),
        .src0_data  (src0_data),
        .src1_req   (src1_req),
        .src1_data  (src1_data),
        .src2_req   (src2_req),
        .src2_data  (src2_data),
        .SEL        (SEL),
        .Y          (Y),
        .blank      (blank),
        .grant      (grant),
        .frame_tick (frame_tick)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic exp_lzb(input logic [15:0] data, input logic [1:0] sel, input logic en);
        logic [15:0] upper;
        upper = data >> (4 * int'(sel));
        return en && (sel != 2'd0) && (upper == 16'd0);
    endfunction

    // Queue n consecutive digit steps of one frame starting at first_sel.
    task automatic push_steps(input logic [15:0] data, input logic [2:0] g, input logic lzb,
                              input int first_sel, input int n, input int last_act);
        step_t s;
        int d;
        for (int i = 0; i < n; i++) begin
            d       = (first_sel + i) % 4;
            s.sel   = 2'(d);
            s.y     = data[4 * d +: 4];
            s.grant = g;
            s.ft    = (d == 0);
            s.blank = exp_lzb(data, s.sel, lzb);
            s.act   = (i == n - 1) ? last_act : 0;
            sb.push_back(s);
        end
    endtask

    task automatic wait_step(output int cycles, output bit timed_out);
        logic [1:0] prev;
        prev      = SEL;
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_50M);
            cycles++;
            if (SEL !== prev) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_50M);
        total++; if (SEL !== 2'd0)        begin bad++; $display("[TB] FAIL reset SEL: got %0d want 0", SEL); end
        total++; if (Y !== 4'd0)          begin bad++; $display("[TB] FAIL reset Y: got %h want 0", Y); end
        total++; if (blank !== 1'b1)      begin bad++; $display("[TB] FAIL reset blank: got %b want 1", blank); end
        total++; if (grant !== 3'b001)    begin bad++; $display("[TB] FAIL reset grant: got %b want 001", grant); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset frame_tick: got %b want 0", frame_tick); end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk_50M);
            total++;
            if (blank !== 1'b1 || SEL !== 2'd0) begin
                bad++;
                $display("[TB] FAIL pre-tick blank: blank=%b SEL=%0d want blank=1 SEL=0", blank, SEL);
            end
        end
    endtask

    task automatic test_scan();
        step_t e;
        int cyc;
        bit to;
        bit first;
        push_steps(16'h0000, 3'b001, 1'b0, 1, 3, 0);
        push_steps(16'h1234, 3'b001, 1'b0, 0, 4, 0);
        push_steps(16'h1234, 3'b001, 1'b0, 0, 1, 0);
        first = 1'b1;
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            // one negedge of the previous step was spent on the settled-blank sample
            if (!first) begin
                total++;
                if (cyc + 1 != 4) begin bad++; $display("[TB] FAIL scan period: got %0d cycles want 4", cyc + 1); end
            end
            first = 1'b0;
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL scan step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL scan blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
        end
    endtask

    task automatic test_lzb();
        step_t e;
        int cyc;
        bit to;
        src0_data = 16'h0050;
        lzb_en    = 1'b1;
        push_steps(16'h1234, 3'b001, 1'b1, 1, 3, 0);
        push_steps(16'h0050, 3'b001, 1'b1, 0, 4, 0);
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lzb step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL lzb blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
        end
    endtask

    task automatic test_overlay();
        step_t e;
        int cyc;
        bit to;
        lzb_en    = 1'b0;
        src0_data = 16'h1234;
        src1_data = 16'h9999;
        src1_req  = 1'b1;
        push_steps(16'h9999, 3'b010, 1'b0, 0, 2, 1);
        push_steps(16'h9999, 3'b010, 1'b0, 2, 2, 0);
        push_steps(16'h9999, 3'b010, 1'b0, 0, 4, 0);
        push_steps(16'h1234, 3'b001, 1'b0, 0, 1, 0);
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL overlay step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL overlay blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
            if (e.act == 1) src1_req = 1'b0;
        end
    endtask

    task automatic test_preempt();
        step_t e;
        int cyc;
        bit to;
        src1_req  = 1'b1;
        src2_data = 16'h5678;
        push_steps(16'h1234, 3'b001, 1'b0, 1, 3, 0);
        push_steps(16'h9999, 3'b010, 1'b0, 0, 1, 1);
        push_steps(16'h9999, 3'b010, 1'b0, 1, 3, 0);
        push_steps(16'h5678, 3'b100, 1'b0, 0, 1, 2);
        push_steps(16'h5678, 3'b100, 1'b0, 1, 3, 0);
        push_steps(16'h5678, 3'b100, 1'b0, 0, 4, 0);
        push_steps(16'h9999, 3'b010, 1'b0, 0, 1, 3);
        push_steps(16'h9999, 3'b010, 1'b0, 1, 3, 0);
        push_steps(16'h9999, 3'b010, 1'b0, 0, 4, 0);
        push_steps(16'h1234, 3'b001, 1'b0, 0, 1, 0);
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL preempt step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL preempt blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
            case (e.act)
                1: src2_req = 1'b1;
                2: src2_req = 1'b0;
                3: src1_req = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_simultaneous();
        step_t e;
        int cyc;
        bit to;
        src1_req  = 1'b1;
        src2_req  = 1'b1;
        src2_data = 16'hABCD;
        push_steps(16'h1234, 3'b001, 1'b0, 1, 3, 0);
        push_steps(16'hABCD, 3'b100, 1'b0, 0, 1, 1);
        push_steps(16'hABCD, 3'b100, 1'b0, 1, 3, 0);
        push_steps(16'h4321, 3'b100, 1'b0, 0, 2, 0);
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL simul step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL simul blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
            if (e.act == 1) src2_data = 16'h4321;
        end
    endtask

    task automatic test_reset_mid();
        step_t e;
        int cyc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            wait_step(cyc, to);
            if (SEL === 2'd2 || to) break;
        end
        total++;
        if (SEL !== 2'd2 || grant !== 3'b100 || Y !== 4'h3) begin
            bad++;
            $display("[TB] FAIL midreset setup: SEL=%0d grant=%b Y=%h want SEL=2 grant=100 Y=3", SEL, grant, Y);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (SEL !== 2'd0 || Y !== 4'd0 || blank !== 1'b1 || grant !== 3'b001 || frame_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset async: SEL=%0d Y=%h blank=%b grant=%b ft=%b want 0 0 1 001 0",
                     SEL, Y, blank, grant, frame_tick);
        end
        src1_req = 1'b0;
        src2_req = 1'b0;
        repeat (2) @(negedge clk_50M);
        rst = 1'b0;
        @(negedge clk_50M);
        total++;
        if (blank !== 1'b1 || SEL !== 2'd0) begin
            bad++;
            $display("[TB] FAIL midreset pre-tick: blank=%b SEL=%0d want blank=1 SEL=0", blank, SEL);
        end
        push_steps(16'h0000, 3'b001, 1'b0, 1, 3, 0);
        push_steps(16'h1234, 3'b001, 1'b0, 0, 1, 0);
        while (sb.size() != 0) begin
            wait_step(cyc, to);
            e = sb.pop_front();
            total++;
            if (to || SEL !== e.sel || Y !== e.y || grant !== e.grant || frame_tick !== e.ft || blank !== 1'b1) begin
                bad++;
                $display("[TB] FAIL midreset step: SEL=%0d Y=%h grant=%b ft=%b blank=%b to=%0d, want SEL=%0d Y=%h grant=%b ft=%b blank=1",
                         SEL, Y, grant, frame_tick, blank, to, e.sel, e.y, e.grant, e.ft);
            end
            @(negedge clk_50M);
            total++;
            if (blank !== e.blank) begin bad++; $display("[TB] FAIL midreset blank: SEL=%0d got %b want %b", SEL, blank, e.blank); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        lzb_en    = 1'b0;
        src0_data = 16'h1234;
        src1_req  = 1'b0;
        src1_data = 16'h0000;
        src2_req  = 1'b0;
        src2_data = 16'h0000;

        test_reset();
        test_scan();
        test_lzb();
        test_overlay();
        test_preempt();
        test_simultaneous();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Scan controller and display arbiter for the 4-digit multiplexed seven-segment display. It divides `clk_50M` down to the digit scan rate, steps the digit select, and shares the display between three sources: source 0 is the always-present counter value, and sources 1 and 2 are requesting overlays such as an alarm or a setting readout. It emits the digit select, the BCD nibble and a blank flag. The existing seven-segment decoder and the 2-4 digit decoder sit downstream and are unchanged.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: input clock frequency.
- `SCAN_HZ`, 1000: digit-step rate.
- `HOLD_TICKS`, 500: minimum overlay display time, in scan ticks.
- `GAP_CYC`, 2500: anti-ghost blank cycles after each digit step. Must be less than `CLK_HZ/SCAN_HZ`.

Ports:
- `clk_50M`  in  1  sole clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `lzb_en`  in  1  leading-zero blanking enable.
- `src0_data`  in  16  default source, 4 BCD digits; [3:0] is digit 0.
- `src1_req`  in  1  overlay 1 request.
- `src1_data`  in  16  overlay 1 digits.
- `src2_req`  in  1  overlay 2 request. Highest priority.
- `src2_data`  in  16  overlay 2 digits.
- `SEL`  out  2  active digit index.
- `Y`  out  4  BCD nibble for `SEL`.
- `blank`  out  1  when high, the downstream stage blanks all segments.
- `grant`  out  3  one-hot owner of the displayed frame.
- `frame_tick`  out  1  one-cycle pulse when a new frame is latched.

## Operation
- **Prescaler:** counts 0..`CLK_HZ/SCAN_HZ`-1 and wraps. `tick` is an internal one-cycle pulse at terminal count.
- **Scan:** `SEL` increments on each `tick` and wraps 3→0.
- **Frame boundary:** a `tick` while `SEL`==3.
  - At the boundary, the arbiter result is applied.
  - The 16-bit frame register loads the newly granted source's data.
  - `frame_tick` pulses.
  - Data changes between boundaries are not displayed, so no tearing occurs.
- **Arbiter states:**
  - DEFAULT: `grant`=001.
  - OV1: `grant`=010.
  - OV2: `grant`=100.
- **Arbiter rules:** requests are evaluated only at frame boundaries.
  - DEFAULT: `src2_req` → OV2; else `src1_req` → OV1; else stay.
  - OV1: `src2_req` → OV2, which preempts regardless of hold. Else, if `src1_req`==0 and hold==0 → DEFAULT. Else stay.
  - OV2: if `src2_req`==0 and hold==0, re-arbitrate: `src1_req` → OV1, else DEFAULT. Else stay.
- **Hold counter:**
  - Loaded with `HOLD_TICKS` on entry to OV1 or OV2. Not reloaded on stay.
  - Decrements on each `tick` and saturates at 0.
  - Held at 0 in DEFAULT.
- **Digit output:** `Y` = frame nibble [4·SEL+3 : 4·SEL]. Nibbles above 9 pass through unchanged.
- **Leading-zero blanking:** with `lzb_en`=1, digit k (k=3..1) is blanked when the frame nibbles k..3 are all 0. Digit 0 is never blanked by this rule.
- **Gap blanking:** `blank`=1 for the first `GAP_CYC` cycles after every `SEL` change.
- **Combined blank:** `blank` is the OR of gap blanking and leading-zero blanking.

## Timing
- All outputs are registered.
- `SEL`, `Y`, `grant`, `frame_tick` and the start of the blank gap update on the clock edge following `tick`. Latency from `tick` is 1 cycle.
- Request-to-display latency: a request set just after a boundary is displayed at the next boundary, worst case 4 scan ticks + 1 cycle.
- A request pulse that is low at the boundary is ignored. Requests are level-sensitive and must be held.
- Simultaneous `src1_req` and `src2_req` at a boundary: OV2 wins.
- Reset values:
  - prescaler 0
  - `SEL`=0
  - `Y`=0
  - `blank`=1
  - `grant`=001
  - frame=0
  - hold=0
  - `frame_tick`=0
- Reset mid-frame aborts immediately.
- After reset is released, `blank` stays 1 until the first `tick`.
- The first frame is latched at the first boundary after reset, i.e. after the 4th `tick`.

## Structure
- Package `display_pkg`:
  - `NUM_DIGITS`=4
  - source-index constants `SRC_DEF`/`SRC_OV1`/`SRC_OV2`
  - arbiter state enum
  - one-hot grant constants
- Sub-module `scan_prescaler` (parameters `DIV`, `GAP`): generates `tick` and the gap-active flag.
- The arbiter, hold counter, frame register and digit mux stay in the top level.

## Test plan
All scenarios use `CLK_HZ`=40, `SCAN_HZ`=10 (divide by 4), `HOLD_TICKS`=6 and `GAP_CYC`=1.
- **Reset and scan:** apply reset, then `src0_data`=16'h1234, with no requests.
  - `SEL` cycles 0,1,2,3 every 4 clocks.
  - After the first boundary, `Y` shows 4,3,2,1.
  - `grant`=001.
  - `blank` is high for 1 cycle after each step.
- **Leading-zero blanking:** `src0_data`=16'h0050, `lzb_en`=1.
  - `blank` is held on `SEL`=3 and `SEL`=2.
  - On `SEL`=1, `Y`=5 with no extra blank.
  - On `SEL`=0, `Y`=0 and the digit is visible.
- **Overlay and hold:** `src1_data`=16'h9999; `src1_req` is high for 2 ticks, then dropped.
  - `grant`=010 from the next boundary.
  - The overlay stays until hold reaches 0, then returns to 001 at the following boundary, 8 ticks after entry.
- **Preemption:** while in OV1 with hold>0, raise `src2_req`.
  - At the next boundary, `grant`=100 and frame = `src2_data`.
  - Drop `src2_req` while `src1_req` is still high: after hold expires, `grant`=010.
- **Simultaneous requests and no tearing:** raise both requests on the same cycle and change `src2_data` mid-frame.
  - `grant`=100.
  - The displayed nibbles change only after a `frame_tick`.
- **Reset mid-operation:** assert `rst` during OV2 with `SEL`=2.
  - All outputs take their reset values asynchronously on the same cycle.
